// File: rtl/serial_frame_pkg.sv
// Shared types and helpers for the serial frame controller.
//   frame_state_t : controller FSM encoding (IDLE waits for start, SHIFT collects data bits)
//   cnt_width()   : bit-counter width for a given frame width
package serial_frame_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } frame_state_t;

    // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/shift_reg_en.sv
// WIDTH-bit serial-in / parallel-out shift register, MSB first.
//   clk   : rising-edge clock
//   clr   : synchronous clear, dominates en
//   en    : shift enable; when high d enters at bit 0 and the contents move up one place
//   d     : serial data input
//   q     : parallel contents
module shift_reg_en #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             d,
    output logic [WIDTH-1:0] q
);

    // Truncating cast drops the oldest bit as the new one enters.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= WIDTH'({q, d});
        end
    end

endmodule

// File: rtl/serial_frame_ctrl.sv
// Serial frame controller: detects a start bit, shifts in WIDTH data bits (MSB first),
// captures the word and offers it on a valid/ready handshake with a sticky overrun flag.
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   enable       : advance qualifier for FSM, counter and shifter (handshake runs regardless)
//   in           : serial data
//   out_ready    : consumer accepts out this cycle
//   clr_overrun  : clears the sticky overrun flag
//   out          : last captured word
//   out_valid    : out holds an unconsumed word
//   busy         : registered copy of (state == SHIFT)
//   overrun      : a completed frame was dropped because out was still occupied
module serial_frame_ctrl
    import serial_frame_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter logic        START_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             in,
    input  logic             out_ready,
    input  logic             clr_overrun,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int unsigned      CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    frame_state_t     state;
    frame_state_t     state_next;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] shifter;
    logic [WIDTH-1:0] word_c;
    logic             start_c;
    logic             shift_en_c;
    logic             frame_done_c;
    logic             drop_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start_c)      state_next = SHIFT;
            SHIFT:   if (frame_done_c) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM decode: start detection, shift qualifier, end of frame
    always_comb begin
        start_c      = 1'b0;
        shift_en_c   = 1'b0;
        frame_done_c = 1'b0;
        unique case (state)
            IDLE: begin
                start_c = enable && (in == START_LEVEL);
            end
            SHIFT: begin
                shift_en_c   = enable;
                frame_done_c = enable && (bit_cnt == LAST_BIT);
            end
            default: begin
                start_c = 1'b0;
            end
        endcase
    end

    // Data bit counter; restarts on every start bit and after the last bit
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt <= '0;
        end else if (start_c) begin
            bit_cnt <= '0;
        end else if (shift_en_c) begin
            bit_cnt <= frame_done_c ? '0 : bit_cnt + CNT_W'(1);
        end
    end

    shift_reg_en #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk (clk),
        .clr (reset),
        .en  (shift_en_c),
        .d   (in),
        .q   (shifter)
    );

    // Completed word includes the bit arriving on the final enabled cycle.
    assign word_c = WIDTH'({shifter, in});

    // A finished frame is dropped only if the held word is not being consumed now.
    assign drop_c = frame_done_c && out_valid && !out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
        end else begin
            busy <= (state_next == SHIFT);
        end
    end

    // Output register and handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else if (frame_done_c && !drop_c) begin
            out       <= word_c;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky overrun; a new drop beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (drop_c) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule
